// File: rtl/smpl_ring_if.sv
// smpl_ring_if: strobe/data bus between ctrl and the circular sample memory
//   master drives clr_i, wrt_i, d_i, read_i, lifo_i; slave returns q_o, vld_o, cnt_o, full_o, empty_o, ovf_o
interface smpl_ring_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                       clr_i;
  logic                       wrt_i;
  logic [WIDTH-1:0]           d_i;
  logic                       read_i;
  logic                       lifo_i;
  logic [WIDTH-1:0]           q_o;
  logic                       vld_o;
  logic [$clog2(DEPTH+1)-1:0] cnt_o;
  logic                       full_o;
  logic                       empty_o;
  logic                       ovf_o;
  modport master (output clr_i, wrt_i, d_i, read_i, lifo_i, input q_o, vld_o, cnt_o, full_o, empty_o, ovf_o);
  modport slave  (input clr_i, wrt_i, d_i, read_i, lifo_i, output q_o, vld_o, cnt_o, full_o, empty_o, ovf_o);
endinterface

// File: rtl/smpl_ring.sv
// smpl_ring: circular sample memory that overwrites the oldest entry when full, read newest or oldest first
//   clk_i/rst_in: clock and async active-low reset; bus: smpl_ring_if slave (strobes in, registered data/flags out)
module smpl_ring #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic        clk_i,
  input logic        rst_in,
  smpl_ring_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             vld_q, vld_d, ovf_q, ovf_d;
  logic             full, empty, wr, rd;
  always_comb begin
    full     = cnt_q == CW'(DEPTH);
    empty    = cnt_q == '0;
    wr       = bus.wrt_i && !bus.clr_i;
    rd       = bus.read_i && !bus.wrt_i && !bus.clr_i && !empty;
    // when full the low count bits wrap to 0, so the oldest slot is wr_ptr itself
    rd_idx   = bus.lifo_i ? wr_ptr_q - AW'(1) : wr_ptr_q - cnt_q[AW-1:0];
    wr_ptr_d = bus.clr_i ? '0 : wr ? wr_ptr_q + AW'(1) : (rd && bus.lifo_i) ? wr_ptr_q - AW'(1) : wr_ptr_q;
    cnt_d    = bus.clr_i ? '0 : wr ? (full ? cnt_q : cnt_q + CW'(1)) : rd ? cnt_q - CW'(1) : cnt_q;
    ovf_d    = bus.clr_i ? 1'b0 : ovf_q || (wr && full);
    vld_d    = rd;
    q_d      = rd ? mem[rd_idx] : q_q;
  end
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      q_q      <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
    end
  end
  always_ff @(posedge clk_i) if (wr) mem[wr_ptr_q] <= bus.d_i;
  assign bus.q_o     = q_q;
  assign bus.vld_o   = vld_q;
  assign bus.cnt_o   = cnt_q;
  assign bus.full_o  = full;
  assign bus.empty_o = empty;
  assign bus.ovf_o   = ovf_q;
endmodule

// File: tb/tb_smpl_ring.sv
// tb_smpl_ring: directed and random checks of smpl_ring against a queue model of the sample history
module tb_smpl_ring;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  logic clk_i = 1'b0;
  logic rst_in = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_q = '0;
  logic m_vld = 1'b0;
  logic m_ovf = 1'b0;
  smpl_ring_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  smpl_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk_i(clk_i), .rst_in(rst_in), .bus(bus));
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, "_q"}, 64'(bus.q_o), 64'(m_q));
    chk({tag, "_vld"}, 64'(bus.vld_o), 64'(m_vld));
    chk({tag, "_cnt"}, 64'(bus.cnt_o), 64'(mq.size()));
    chk({tag, "_full"}, 64'(bus.full_o), 64'(mq.size() == DEPTH));
    chk({tag, "_empty"}, 64'(bus.empty_o), 64'(mq.size() == 0));
    chk({tag, "_ovf"}, 64'(bus.ovf_o), 64'(m_ovf));
  endtask
  task automatic model_reset();
    mq.delete();
    m_q = '0;
    m_vld = 1'b0;
    m_ovf = 1'b0;
  endtask
  task automatic cyc(input string tag, input logic c, input logic w, input logic [WIDTH-1:0] dd, input logic r, input logic l);
    bus.clr_i = c;
    bus.wrt_i = w;
    bus.d_i = dd;
    bus.read_i = r;
    bus.lifo_i = l;
    @(posedge clk_i);
    #1;
    m_vld = 1'b0;
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (w) begin
      mq.push_back(dd);
      if (mq.size() > DEPTH) begin
        void'(mq.pop_front());
        m_ovf = 1'b1;
      end
    end else if (r && mq.size() > 0) begin
      m_q = l ? mq.pop_back() : mq.pop_front();
      m_vld = 1'b1;
    end
    bus.clr_i = 1'b0;
    bus.wrt_i = 1'b0;
    bus.read_i = 1'b0;
    bus.lifo_i = 1'b0;
    chk_all(tag);
  endtask
  initial begin
    bus.clr_i = 1'b0;
    bus.wrt_i = 1'b0;
    bus.d_i = '0;
    bus.read_i = 1'b0;
    bus.lifo_i = 1'b0;
    #12;
    chk_all("reset");
    @(negedge clk_i);
    rst_in = 1'b1;
    for (int i = 1; i <= 3; i++) cyc("t1_wr", 0, 1, WIDTH'(i), 0, 0);
    for (int i = 3; i >= 1; i--) begin
      cyc("t1_rd", 0, 0, '0, 1, 1);
      chk("t1_qconst", 64'(bus.q_o), 64'(i));
    end
    chk("t1_empty", 64'(bus.empty_o), 64'd1);
    cyc("t1_idle", 0, 0, '0, 0, 0);
    cyc("t3_rd_empty", 0, 0, '0, 1, 1);
    chk("t3_qhold", 64'(bus.q_o), 64'd1);
    for (int i = 1; i <= 6; i++) cyc("t2_wr", 0, 1, WIDTH'(i), 0, 0);
    chk("t2_full", 64'(bus.full_o), 64'd1);
    chk("t2_ovf", 64'(bus.ovf_o), 64'd1);
    for (int i = 3; i <= 6; i++) begin
      cyc("t2_rd", 0, 0, '0, 1, 0);
      chk("t2_qconst", 64'(bus.q_o), 64'(i));
    end
    chk("t2_ovf_stays", 64'(bus.ovf_o), 64'd1);
    cyc("t4_wr", 0, 1, 32'h11, 0, 0);
    cyc("t4_wr", 0, 1, 32'h22, 0, 0);
    cyc("t4_wr_rd", 0, 1, 32'hA5, 1, 1);
    chk("t4_cnt", 64'(bus.cnt_o), 64'd3);
    cyc("t4_rd", 0, 0, '0, 1, 1);
    chk("t4_q", 64'(bus.q_o), 64'hA5);
    for (int i = 0; i < 4; i++) cyc("t5_fill", 0, 1, WIDTH'(32'hB0 + i), 0, 0);
    chk("t5_ovf_pre", 64'(bus.ovf_o), 64'd1);
    cyc("t5_clr", 1, 1, 32'hDEAD, 0, 0);
    chk("t5_cnt", 64'(bus.cnt_o), 64'd0);
    chk("t5_ovf", 64'(bus.ovf_o), 64'd0);
    cyc("t6_wr", 0, 1, 32'hA, 0, 0);
    cyc("t6_wr", 0, 1, 32'hB, 0, 0);
    cyc("t6_wr", 0, 1, 32'hC, 0, 0);
    cyc("t6_wr", 0, 1, 32'hD, 0, 0);
    cyc("t6_l", 0, 0, '0, 1, 1);
    chk("t6_q0", 64'(bus.q_o), 64'hD);
    cyc("t6_f", 0, 0, '0, 1, 0);
    chk("t6_q1", 64'(bus.q_o), 64'hA);
    cyc("t6_l", 0, 0, '0, 1, 1);
    chk("t6_q2", 64'(bus.q_o), 64'hC);
    cyc("t6_f", 0, 0, '0, 1, 0);
    chk("t6_q3", 64'(bus.q_o), 64'hB);
    for (int i = 0; i < 3; i++) cyc("t7_wr", 0, 1, WIDTH'(32'h70 + i), 0, 0);
    cyc("t7_rd", 0, 0, '0, 1, 1);
    bus.read_i = 1'b1;
    bus.lifo_i = 1'b1;
    @(posedge clk_i);
    #3;
    rst_in = 1'b0;
    #1;
    model_reset();
    chk_all("t7_async");
    bus.read_i = 1'b0;
    bus.lifo_i = 1'b0;
    @(negedge clk_i);
    rst_in = 1'b1;
    cyc("t7_wr", 0, 1, 32'h1234_5678, 0, 0);
    cyc("t7_rd", 0, 0, '0, 1, 0);
    chk("t7_q", 64'(bus.q_o), 64'h1234_5678);
    for (int i = 0; i < 400; i++)
      cyc("rnd", ($urandom_range(15) == 0), $urandom_range(1) == 1, WIDTH'($urandom), $urandom_range(1) == 1, $urandom_range(1) == 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
